mux_arb_pipe: RTL and testbench
===============================

MUX_ARB_PIPE -- requirements
Module: mux_arb_pipe

Interface
REQ-001 The block SHALL have parameter SIZE, default 8, meaning the data width per channel in bits.
REQ-002 The block SHALL have parameter CHANNELS, default 8, meaning the number of input channels; the legal range is 2..16.
REQ-003 The block SHALL have parameter SEL_W, default 3, meaning the select/channel-index width; SEL_W SHALL equal ceil(log2(CHANNELS)).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port data_in, input, CHANNELS*SIZE bits: channel k occupies bits [k*SIZE +: SIZE].
REQ-007 The block SHALL have port valid_in, input, CHANNELS bits: per-channel data-valid.
REQ-008 The block SHALL have port ready_out, output, CHANNELS bits: per-channel accept, combinational.
REQ-009 The block SHALL have port mode, input, 1 bit: 0 = direct select by code, 1 = round-robin arbitration.
REQ-010 The block SHALL have port code, input, SEL_W bits: the channel select used in direct mode.
REQ-011 The block SHALL have port data_out, output, SIZE bits: the registered selected data.
REQ-012 The block SHALL have port valid_out, output, 1 bit: data_out holds an untaken word.
REQ-013 The block SHALL have port ready_in, input, 1 bit: the downstream accepts data_out.
REQ-014 The block SHALL have port chan_out, output, SEL_W bits: the source channel index of data_out.
REQ-015 The block SHALL have port sel_err, output, 1 bit: registered one-cycle pulse for an illegal direct-mode code.

Function
REQ-016 The block SHALL compute load = !valid_out || ready_in; the output register SHALL accept a new word only when load=1.
REQ-017 In direct mode (mode=0), when code<CHANNELS, the block SHALL assert ready_out[code]=load and hold all other ready_out bits at 0.
REQ-018 In round-robin mode (mode=1), the grant SHALL be the first channel with valid_in=1 searching ptr+1, ptr+2, ... with wrap from CHANNELS-1 to 0, ptr included last; ready_out[grant]=load and all other bits SHALL be 0.
REQ-019 A transfer SHALL occur when ready_out[k] && valid_in[k]; on that edge data_out<=channel k data, chan_out<=k, valid_out<=1.
REQ-020 When load=1 and no transfer occurs, the block SHALL set valid_out<=0 on the edge; data_out and chan_out SHALL hold their previous values.
REQ-021 When valid_out=1 and ready_in=0, data_out, chan_out and valid_out SHALL remain stable, and all ready_out bits SHALL be 0.
REQ-022 Latency SHALL be exactly 1 cycle from input transfer to valid_out; with ready_in held at 1, throughput SHALL be one word per cycle.
REQ-023 The round-robin pointer ptr SHALL update to k only on a round-robin-mode transfer from channel k; it SHALL be unchanged otherwise, including while in direct mode.
REQ-024 A mode change SHALL take effect in the same cycle it is applied, and an already-registered output word SHALL be unaffected.
REQ-025 In direct mode with code>=CHANNELS (possible only when CHANNELS is not a power of 2), all ready_out bits SHALL be 0, no transfer SHALL occur, and sel_err SHALL be 1 in the following cycle if load=1 in the current cycle.
REQ-026 sel_err SHALL be 0 in every other cycle.
REQ-027 Outputs SHALL never be X: data_out is a value previously loaded, or 0 after reset.

Reset
REQ-028 While rst=1 at a clock edge, the block SHALL set valid_out=0, data_out=0, chan_out=0, sel_err=0 and ptr=CHANNELS-1, so that the first round-robin search starts at channel 0.
REQ-029 While rst=1, all ready_out bits SHALL be 0.
REQ-030 Reset applied mid-transfer SHALL discard the held word, with no handshake completed.
REQ-031 The first transfer SHALL be possible in the first cycle after rst deasserts.

Verification
REQ-032 Direct mode: with CHANNELS=8, code=5, valid_in=8'hFF, ready_in=1 and channel 5 data=8'hA5 -> the next cycle shows data_out=8'hA5, chan_out=5, valid_out=1, and ready_out=8'b0010_0000.
REQ-033 Round-robin fairness: with mode=1, all valid_in=1 and ready_in=1 after reset -> chan_out sequence 0,1,2,...,7,0 on consecutive cycles.
REQ-034 Round-robin skip and wrap: with mode=1, ptr=6 and only channels 2 and 7 valid -> grants 7 then 2 then 7.
REQ-035 Backpressure: with ready_in=0 for 3 cycles while valid_out=1 -> data_out and chan_out are unchanged and ready_out=0; when ready_in rises, a new word loads the same cycle.
REQ-036 Illegal code: with CHANNELS=5, mode=0, code=6 and valid_out=0 -> ready_out=0, and sel_err=1 for exactly one cycle.
REQ-037 Reset mid-stream: rst=1 while valid_out=1 -> the next cycle shows valid_out=0, data_out=0, chan_out=0, and the next round-robin grant is channel 0.

Source files
------------

// File: rtl/mux_arb_pipe.sv
// Channel multiplexer with direct-select and round-robin modes, feeding one
// registered output stage with a valid/ready handshake.
module mux_arb_pipe #(
  parameter int SIZE     = 8,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CHANNELS*SIZE-1:0] data_in,
  input  logic [CHANNELS-1:0]      valid_in,
  output logic [CHANNELS-1:0]      ready_out,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         code,
  output logic [SIZE-1:0]          data_out,
  output logic                     valid_out,
  input  logic                     ready_in,
  output logic [SEL_W-1:0]         chan_out,
  output logic                     sel_err
);

  logic             load;
  logic             code_ok;
  logic             grant_vld;
  logic             sel_ok;
  logic             xfer;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] grant;
  logic [SEL_W-1:0] sel_ch;
  logic [SIZE-1:0]  sel_data;

  // The output register can take a word when it is empty or being drained.
  assign load    = !valid_out || ready_in;
  assign code_ok = int'(code) < CHANNELS;

  // Round-robin search starts just after the last granted channel and visits
  // ptr itself last.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    grant_vld = 1'b0;
    grant     = '0;
    for (int i = 1; i <= CHANNELS; i++) begin
      if (!grant_vld && valid_in[(int'(ptr) + i) % CHANNELS]) begin
        grant_vld = 1'b1;
        grant     = SEL_W'((int'(ptr) + i) % CHANNELS);
      end
    end
  end

  always_comb begin
    sel_ch    = mode ? grant : code;
    sel_ok    = mode ? grant_vld : code_ok;
    sel_data  = '0;
    ready_out = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (int'(sel_ch) == k) begin
        sel_data = data_in[k*SIZE +: SIZE];
        if (!rst && sel_ok) ready_out[k] = load;
      end
    end
  end

  assign xfer = |(ready_out & valid_in);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    if (rst) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      chan_out  <= '0;
      sel_err   <= 1'b0;
      ptr       <= SEL_W'(CHANNELS - 1);
    end else begin
      sel_err <= !mode && !code_ok && load;
      if (load) begin
        valid_out <= xfer;
        if (xfer) begin
          data_out <= sel_data;
          chan_out <= sel_ch;
          if (mode) ptr <= sel_ch;
        end
      end
    end
  end

endmodule

// File: tb/tb_mux_arb_pipe.sv
// Scoreboard bench for mux_arb_pipe: an 8-channel instance under directed and
// random traffic, plus a 5-channel instance for illegal direct-mode codes.
module tb_mux_arb_pipe;

  typedef struct {
    logic [7:0] data;
    logic [2:0] chan;
  } word_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] data_in;
  logic [7:0]  valid_in;
  logic [7:0]  ready_out;
  logic        mode;
  logic [2:0]  code;
  logic [7:0]  data_out;
  logic        valid_out;
  logic        ready_in;
  logic [2:0]  chan_out;
  logic        sel_err;

  logic        rst5;
  logic [39:0] data5;
  logic [4:0]  valid5;
  logic [4:0]  ready5;
  logic        mode5;
  logic [2:0]  code5;
  logic [7:0]  dout5;
  logic        vout5;
  logic        rin5;
  logic [2:0]  chan5;
  logic        serr5;

  int    checks = 0;
  int    errors = 0;
  word_t exp_q[$];

  // Reference model state: whether the output register holds a word, and the
  // channel the round-robin search continues after.
  bit    m_vo;
  int    m_ptr;

  always #5 clk = ~clk;

  mux_arb_pipe #(.SIZE(8), .CHANNELS(8), .SEL_W(3)) u_dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_out), .mode(mode), .code(code), .data_out(data_out),
    .valid_out(valid_out), .ready_in(ready_in), .chan_out(chan_out),
    .sel_err(sel_err)
  );

  mux_arb_pipe #(.SIZE(8), .CHANNELS(5), .SEL_W(3)) u_dut5 (
    .clk(clk), .rst(rst5), .data_in(data5), .valid_in(valid5),
    .ready_out(ready5), .mode(mode5), .code(code5), .data_out(dout5),
    .valid_out(vout5), .ready_in(rin5), .chan_out(chan5),
    .sel_err(serr5)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, check ready_out against the model, record the
  // expected output word, then advance to just after the next rising edge.
  task automatic step(input logic r, input logic m, input logic [2:0] c,
                      input logic [7:0] v, input logic ri, input logic [63:0] d,
                      input string tag);
    logic [7:0] exp_ready;
    int         grant;
    bit         load;
    rst = r; mode = m; code = c; valid_in = v; ready_in = ri; data_in = d;
    #1;
    exp_ready = '0;
    grant     = -1;
    load      = !m_vo || ri;
    if (!r) begin
      if (!m) grant = int'(c);
      else begin
        for (int i = 1; i <= 8; i++) begin
          if (v[(m_ptr + i) % 8]) begin
            grant = (m_ptr + i) % 8;
            break;
          end
        end
      end
      if (grant >= 0 && load) exp_ready[grant] = 1'b1;
    end
    check({tag, "_ready"}, ready_out, exp_ready);
    if (r) begin
      m_vo  = 1'b0;
      m_ptr = 7;
      exp_q.delete();
    end else if (load) begin
      if (grant >= 0 && v[grant]) begin
        exp_q.push_back('{d[grant*8 +: 8], 3'(grant)});
        m_vo = 1'b1;
        if (m) m_ptr = grant;
      end else begin
        m_vo = 1'b0;
      end
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Monitor: at each falling edge, pop and compare taken words, and confirm a
  // word stalled by the downstream stays put.
  initial begin : monitor
    bit         prev_hold = 1'b0;
    logic [7:0] prev_data;
    logic [2:0] prev_chan;
    word_t      w;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_hold = 1'b0;
      end else begin
        check("sel_err_8ch", sel_err, 1'b0);
        if (prev_hold) begin
          check("stall_valid", valid_out, 1'b1);
          check("stall_data", data_out, prev_data);
          check("stall_chan", chan_out, prev_chan);
        end
        if (valid_out && ready_in) begin
          if (exp_q.size() == 0) begin
            check("sb_spurious_word", valid_out, 1'b0);
          end else begin
            w = exp_q.pop_front();
            check("sb_data", data_out, w.data);
            check("sb_chan", chan_out, w.chan);
          end
        end
        prev_hold = valid_out && !ready_in;
        prev_data = data_out;
        prev_chan = chan_out;
      end
    end
  end

  initial begin : stimulus
    logic [63:0] d;
    rst = 1'b1; mode = 1'b0; code = '0; valid_in = '0; ready_in = 1'b0; data_in = '0;
    rst5 = 1'b1; mode5 = 1'b0; code5 = '0; valid5 = '0; rin5 = 1'b0; data5 = '0;
    m_vo = 1'b0; m_ptr = 7;
    @(posedge clk); #1;
    step(1, 0, 0, 8'h00, 0, 64'h0, "rst");
    check("rst_valid_out", valid_out, 1'b0);
    check("rst_data_out", data_out, 8'h00);
    check("rst_chan_out", chan_out, 3'd0);

    // Fairness: all channels valid -> 0..7 then 0 again.
    for (int i = 0; i < 9; i++) step(0, 1, 0, 8'hFF, 1, rand64(), "rr_fair");

    // Direct select of channel 5.
    d = rand64();
    d[40 +: 8] = 8'hA5;
    step(0, 0, 3'd5, 8'hFF, 1, d, "direct5");
    check("direct5_data", data_out, 8'hA5);
    check("direct5_chan", chan_out, 3'd5);

    // Skip and wrap: park ptr on 6, then only channels 2 and 7 valid.
    step(0, 1, 0, 8'h40, 1, rand64(), "rr_park6");
    for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h84, 1, rand64(), "rr_skip");

    // Backpressure for three cycles, then release loads a new word at once.
    step(0, 1, 0, 8'hFF, 1, rand64(), "bp_load");
    for (int i = 0; i < 3; i++) step(0, 1, 0, 8'hFF, 0, rand64(), "bp_hold");
    step(0, 1, 0, 8'hFF, 1, rand64(), "bp_release");

    // Randomised traffic with mode switching and random backpressure.
    for (int i = 0; i < 300; i++) begin
      step(0, 1'($urandom_range(0, 1)), 3'($urandom), 8'($urandom & $urandom_range(0, 255)),
           ($urandom_range(0, 3) != 0), rand64(), "rand");
    end

    // Reset while a word is held: it is discarded and the search restarts at 0.
    step(0, 1, 0, 8'hFF, 1, rand64(), "pre_rst");
    step(1, 1, 0, 8'hFF, 0, rand64(), "mid_rst");
    check("mid_rst_valid", valid_out, 1'b0);
    check("mid_rst_data", data_out, 8'h00);
    check("mid_rst_chan", chan_out, 3'd0);
    step(0, 1, 0, 8'hFF, 1, rand64(), "post_rst");
    check("post_rst_chan", chan_out, 3'd0);

    for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h00, 1, 64'h0, "drain");
    check("sb_leftover", exp_q.size(), 0);

    // Five-channel instance: illegal direct code 6.
    @(posedge clk); #1;
    rst5 = 1'b0; mode5 = 1'b0; code5 = 3'd6; valid5 = 5'h1F; rin5 = 1'b1;
    data5 = {$urandom, 8'($urandom)};
    #1 check("ill_ready", ready5, 5'b0);
    @(posedge clk); #1;
    check("ill_sel_err", serr5, 1'b1);
    check("ill_no_word", vout5, 1'b0);
    code5 = 3'd2;
    #1 check("legal2_ready", ready5, 5'b00100);
    @(posedge clk); #1;
    check("ill_pulse_once", serr5, 1'b0);
    check("legal2_valid", vout5, 1'b1);
    check("legal2_chan", chan5, 3'd2);
    check("legal2_data", dout5, data5[16 +: 8]);
    rin5 = 1'b0; code5 = 3'd6;
    #1 check("ill_stall_ready", ready5, 5'b0);
    @(posedge clk); #1;
    check("ill_stall_no_err", serr5, 1'b0);
    check("ill_stall_valid", vout5, 1'b1);
    rin5 = 1'b1;
    @(posedge clk); #1;
    check("ill_release_err", serr5, 1'b1);
    check("ill_release_valid", vout5, 1'b0);
    code5 = 3'd0; valid5 = '0;
    @(posedge clk); #1;
    check("ill_err_clear", serr5, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
